// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared command/state encodings for the SPI-to-RAM burst slave
package spi_ram_pkg;
   localparam int CMD_W = 2;
   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;
   // HOLD parks a finished single-word frame, ignoring MOSI until SS_n rises
   typedef enum logic [2:0] {
      IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA_RX, RD_DATA_TX, HOLD
   } state_e;
   function automatic state_e cmd_state(cmd_e c);
      return c == CMD_WR_ADDR ? WR_ADDR :
             c == CMD_WR_DATA ? WR_DATA :
             c == CMD_RD_ADDR ? RD_ADDR : RD_DATA_RX;
   endfunction
endpackage

// File: rtl/spi_ram_sp_mem.sv
// spi_ram_sp_mem: single-port RAM, synchronous write, registered one-cycle read
module spi_ram_sp_mem #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] memory [2**ADDR_W];
   // write port and registered read share one address
   always_ff @(posedge clk_i) begin
      if (we_i) memory[addr_i] <= wdata_i;
      if (re_i) rdata_o <= memory[addr_i];
   end
endmodule

// File: rtl/spi_ram_burst_slave.sv
// spi_ram_burst_slave: SPI frame decoder driving a single-port RAM with optional burst auto-increment
module spi_ram_burst_slave
   import spi_ram_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter bit AUTO_INC = 1'b1
) (
   input  logic CLK,
   input  logic rst_n,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO
);
   localparam int SH_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = (SH_W > 1) ? $clog2(SH_W) : 1;
   localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SH_W-1:0]   sh_q, sh_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic              com_q, com_d, rd_req_q, rd_req_d, load_q, load_d;
   cmd_e              com_cmd_q, com_cmd_d;
   logic [DATA_W-1:0] rdata;
   logic              we, re;

   // a complete word commits on the following edge even if SS_n has risen;
   // a read is only issued while the frame is still open
   assign we   = com_q && com_cmd_q == CMD_WR_DATA;
   assign re   = rd_req_q && !SS_n;
   assign MISO = tx_q[DATA_W-1];

   spi_ram_sp_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
      .clk_i   (CLK),
      .we_i    (we),
      .re_i    (re),
      .addr_i  (we ? wr_addr_q : rd_addr_q),
      .wdata_i (sh_q[DATA_W-1:0]),
      .rdata_o (rdata)
   );

   // next state, bit counting, commit scheduling and MISO shifting
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      tx_d      = load_q ? rdata : tx_q << 1;
      com_d     = 1'b0;
      com_cmd_d = com_cmd_q;
      rd_req_d  = 1'b0;
      load_d    = re;
      wr_addr_d = (com_q && com_cmd_q == CMD_WR_ADDR) ? sh_q[ADDR_W-1:0] :
                  (we && AUTO_INC) ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
      rd_addr_d = (com_q && com_cmd_q == CMD_RD_ADDR) ? sh_q[ADDR_W-1:0] :
                  (re && AUTO_INC) ? rd_addr_q + ADDR_W'(1) : rd_addr_q;
      case (state_q)
         IDLE: begin
            state_d = CMD;
            cnt_d   = '0;
         end
         CMD: begin
            sh_d  = {sh_q[SH_W-2:0], MOSI};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CMD_W - 1)) begin
               cnt_d   = '0;
               state_d = cmd_state(cmd_e'({sh_q[0], MOSI}));
            end
         end
         WR_ADDR, RD_ADDR, WR_DATA, RD_DATA_RX: begin
            sh_d  = {sh_q[SH_W-2:0], MOSI};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == ((state_q == WR_ADDR || state_q == RD_ADDR) ? A_LAST : D_LAST)) begin
               cnt_d     = '0;
               com_d     = state_q != RD_DATA_RX;
               com_cmd_d = state_q == WR_ADDR ? CMD_WR_ADDR :
                           state_q == RD_ADDR ? CMD_RD_ADDR : CMD_WR_DATA;
               rd_req_d  = state_q == RD_DATA_RX;
               state_d   = state_q == RD_DATA_RX ? RD_DATA_TX :
                           (state_q == WR_DATA && AUTO_INC) ? WR_DATA : HOLD;
            end
         end
         RD_DATA_TX: begin
            cnt_d    = cnt_q == D_LAST ? '0 : cnt_q + CNT_W'(1);
            rd_req_d = AUTO_INC && cnt_q == D_LAST;
         end
         default: ;
      endcase
      if (SS_n) begin
         state_d  = IDLE;
         cnt_d    = '0;
         tx_d     = '0;
         com_d    = 1'b0;
         rd_req_d = 1'b0;
         load_d   = 1'b0;
      end
   end

   // state registers; reset drops any pending commit
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sh_q      <= '0;
         tx_q      <= '0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         com_q     <= 1'b0;
         com_cmd_q <= CMD_WR_ADDR;
         rd_req_q  <= 1'b0;
         load_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         tx_q      <= tx_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         com_q     <= com_d;
         com_cmd_q <= com_cmd_d;
         rd_req_q  <= rd_req_d;
         load_q    <= load_d;
      end
   end
endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// tb_spi_ram_burst_slave: directed and randomized checks of the SPI RAM slave against an array model
module tb_spi_ram_burst_slave;
   import spi_ram_pkg::*;

   logic CLK = 1'b0;
   logic rst_n = 1'b0;
   logic ss_a = 1'b1, mosi_a = 1'b0, miso_a;
   logic ss_b = 1'b1, mosi_b = 1'b0, miso_b;

   always #5 CLK = ~CLK;

   spi_ram_burst_slave dut_a (
      .CLK(CLK), .rst_n(rst_n), .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso_a)
   );

   spi_ram_burst_slave #(.ADDR_W(10), .DATA_W(16), .AUTO_INC(1'b0)) dut_b (
      .CLK(CLK), .rst_n(rst_n), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso_b)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0]  mem_a [256];
   logic [15:0] mem_b [1024];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input bit b, input logic ss, input logic mosi);
      if (b) begin ss_b = ss; mosi_b = mosi; end
      else begin ss_a = ss; mosi_a = mosi; end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic send_bits(input bit b, input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) tick(b, 1'b0, v[i]);
   endtask

   task automatic start(input bit b, input logic [1:0] cmd);
      tick(b, 1'b0, 1'b0);
      send_bits(b, 32'(cmd), 2);
   endtask

   task automatic stop(input bit b);
      tick(b, 1'b1, 1'b0);
   endtask

   task automatic addr_frame(input bit b, input logic [1:0] cmd, input int aw, input logic [31:0] addr);
      start(b, cmd);
      send_bits(b, addr, aw);
      tick(b, 1'b0, 1'b0);
      stop(b);
   endtask

   task automatic wr_burst(input bit b, input int aw, input int dw, input logic [31:0] addr,
                           input logic [63:0] words, input int n, input int extra);
      addr_frame(b, 2'b00, aw, addr);
      start(b, 2'b01);
      for (int k = n - 1; k >= 0; k--) send_bits(b, 32'(words >> (k * dw)), dw);
      tick(b, 1'b0, 1'b0);
      for (int i = 0; i < extra; i++) tick(b, 1'b0, 1'($urandom));
      stop(b);
   endtask

   task automatic rd_burst(input bit b, input int aw, input int dw, input logic [31:0] addr,
                           input int nbits, output logic [63:0] got);
      addr_frame(b, 2'b10, aw, addr);
      start(b, 2'b11);
      send_bits(b, $urandom, dw);
      tick(b, 1'b0, 1'($urandom));
      got = '0;
      for (int i = 0; i < nbits; i++) begin
         tick(b, 1'b0, 1'($urandom));
         got = {got[62:0], b ? miso_b : miso_a};
      end
      stop(b);
   endtask

   initial begin
      int a, n, bad;
      logic [63:0] got, exp, w;
      logic [7:0] old;
      logic [15:0] v16;
      repeat (3) @(negedge CLK);
      check("rst_miso", 64'(miso_a), 64'(0));
      check("rst_state", 64'(dut_a.state_q), 64'(IDLE));
      check("rst_wr_addr", 64'(dut_a.wr_addr_q), 64'(0));
      check("rst_rd_addr", 64'(dut_a.rd_addr_q), 64'(0));
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'($urandom);
         dut_a.u_mem.memory[i] <= mem_a[i];
      end
      for (int i = 0; i < 1024; i++) begin
         mem_b[i] = 16'($urandom);
         dut_b.u_mem.memory[i] <= mem_b[i];
      end
      mem_a[8'h10] = 8'h3C;
      mem_a[8'h11] = 8'hC3;
      dut_a.u_mem.memory[8'h10] <= 8'h3C;
      dut_a.u_mem.memory[8'h11] <= 8'hC3;
      @(negedge CLK);
      rst_n = 1'b1;
      @(negedge CLK);
      // read before any RD_ADDR uses address 0
      start(0, 2'b11);
      send_bits(0, 0, 8);
      tick(0, 1'b0, 1'b0);
      got = '0;
      for (int i = 0; i < 8; i++) begin
         tick(0, 1'b0, 1'b0);
         got = {got[62:0], miso_a};
      end
      stop(0);
      check("rd_default_addr0", got, 64'(mem_a[0]));
      check("miso_after_ss", 64'(miso_a), 64'(0));
      // single word write and read back
      wr_burst(0, 8, 8, 8'hF0, 64'hA5, 1, 0);
      mem_a[8'hF0] = 8'hA5;
      check("wr_single_mem", 64'(dut_a.u_mem.memory[8'hF0]), 64'hA5);
      rd_burst(0, 8, 8, 8'hF0, 8, got);
      check("rd_single", got, 64'hA5);
      // burst write wrapping the address
      wr_burst(0, 8, 8, 8'hFE, 64'h112233, 3, 0);
      mem_a[8'hFE] = 8'h11; mem_a[8'hFF] = 8'h22; mem_a[8'h00] = 8'h33;
      check("burst_fe", 64'(dut_a.u_mem.memory[8'hFE]), 64'h11);
      check("burst_ff", 64'(dut_a.u_mem.memory[8'hFF]), 64'h22);
      check("burst_00", 64'(dut_a.u_mem.memory[8'h00]), 64'h33);
      check("burst_wr_addr", 64'(dut_a.wr_addr_q), 64'h01);
      // gapless two-word read
      rd_burst(0, 8, 8, 8'h10, 16, got);
      check("gapless_rd", got, 64'h3CC3);
      check("gapless_miso_idle", 64'(miso_a), 64'(0));
      // aborted write leaves memory alone
      old = mem_a[8'h20];
      addr_frame(0, 2'b00, 8, 8'h20);
      start(0, 2'b01);
      send_bits(0, 32'(~old[7:4]), 4);
      check("abort_miso", 64'(miso_a), 64'(0));
      stop(0);
      check("abort_state", 64'(dut_a.state_q), 64'(IDLE));
      check("abort_mem", 64'(dut_a.u_mem.memory[8'h20]), 64'(old));
      rd_burst(0, 8, 8, 8'h20, 8, got);
      check("abort_rd", got, 64'(old));
      // reset during a data payload
      old = mem_a[8'h40];
      addr_frame(0, 2'b10, 8, 8'h55);
      addr_frame(0, 2'b00, 8, 8'h40);
      start(0, 2'b01);
      send_bits(0, 32'(~old), 7);
      rst_n = 1'b0;
      #1;
      check("rstmid_miso", 64'(miso_a), 64'(0));
      check("rstmid_state", 64'(dut_a.state_q), 64'(IDLE));
      check("rstmid_wr_addr", 64'(dut_a.wr_addr_q), 64'(0));
      check("rstmid_rd_addr", 64'(dut_a.rd_addr_q), 64'(0));
      tick(0, 1'b0, 1'b1);
      tick(0, 1'b0, 1'b1);
      rst_n = 1'b1;
      stop(0);
      tick(0, 1'b1, 1'b0);
      check("rstmid_mem", 64'(dut_a.u_mem.memory[8'h40]), 64'(old));
      // randomized bursts against the array model
      for (int t = 0; t < 12; t++) begin
         a = $urandom_range(0, 255);
         n = $urandom_range(1, 4);
         w = {$urandom, $urandom};
         wr_burst(0, 8, 8, 32'(a), w, n, 0);
         for (int k = 0; k < n; k++) mem_a[(a + k) % 256] = w[(n - 1 - k) * 8 +: 8];
         check("rnd_wr_addr", 64'(dut_a.wr_addr_q), 64'((a + n) % 256));
         a = $urandom_range(0, 255);
         n = $urandom_range(1, 3);
         rd_burst(0, 8, 8, 32'(a), n * 8, got);
         exp = '0;
         for (int k = 0; k < n; k++) exp = {exp[55:0], mem_a[(a + k) % 256]};
         check("rnd_rd", got, exp);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (dut_a.u_mem.memory[i] !== mem_a[i]) bad++;
      check("mem_a_image", 64'(bad), 64'(0));
      // wide single-word instance: extra bits in a frame are ignored
      for (int t = 0; t < 3; t++) begin
         a = $urandom_range(0, 1022);
         v16 = 16'($urandom);
         wr_burst(1, 10, 16, 32'(a), 64'(v16), 1, 16);
         mem_b[a] = v16;
         check("wide_wr_mem", 64'(dut_b.u_mem.memory[a]), 64'(v16));
         check("wide_wr_next", 64'(dut_b.u_mem.memory[a + 1]), 64'(mem_b[a + 1]));
         check("wide_wr_addr", 64'(dut_b.wr_addr_q), 64'(a));
         rd_burst(1, 10, 16, 32'(a), 32, got);
         check("wide_rd", got, {32'h0, v16, 16'h0});
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
